// File: rtl/fifo_stream_drain.sv
// Drains a first-word-fall-through-less FIFO (data one cycle after read) into a
// valid/ready stream through a 2-entry skid buffer, counting handed-off and dropped words.
module fifo_stream_drain #(
  parameter int FIFO_WIDTH = 16,
  parameter int CNT_WIDTH  = 16
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  fifo_empty,
  output logic                  fifo_rd_en,
  input  logic [FIFO_WIDTH-1:0] fifo_data_out,
  input  logic                  fifo_underflow,
  output logic [FIFO_WIDTH-1:0] m_data,
  output logic                  m_valid,
  input  logic                  m_ready,
  output logic [CNT_WIDTH-1:0]  words_out,
  output logic [7:0]            drop_cnt
);

  logic [1:0]            count_reg, count_next;
  logic                  inflight_reg;
  logic [FIFO_WIDTH-1:0] head_reg, head_next;
  logic [FIFO_WIDTH-1:0] tail_reg, tail_next;
  logic [CNT_WIDTH-1:0]  words_reg;
  logic [7:0]            drop_reg;
  logic                  pop;
  logic                  capture;
  logic                  drop;
  logic                  room;

  assign m_valid   = (count_reg != 2'd0);
  assign m_data    = head_reg;
  assign words_out = words_reg;
  assign drop_cnt  = drop_reg;

  assign pop     = m_valid && m_ready;
  assign capture = inflight_reg && !fifo_underflow;
  assign drop    = inflight_reg && fifo_underflow;

  // Buffered plus in-flight words never exceed two, so a read is only issued
  // when a slot is guaranteed free by the time its data arrives.
  assign room       = ({1'b0, count_reg} + {2'b00, inflight_reg}) < 3'd2;
  assign fifo_rd_en = rst_n && !fifo_empty && (room || pop);

  always_comb begin
    head_next  = head_reg;
    tail_next  = tail_reg;
    count_next = count_reg;
    case ({capture, pop})
      2'b11: begin
        if (count_reg == 2'd1) begin
          head_next = fifo_data_out;
        end else begin
          head_next = tail_reg;
          tail_next = fifo_data_out;
        end
      end
      2'b01: begin
        head_next  = tail_reg;
        count_next = count_reg - 2'd1;
      end
      2'b10: begin
        if (count_reg == 2'd0) begin
          head_next = fifo_data_out;
        end else begin
          tail_next = fifo_data_out;
        end
        count_next = count_reg + 2'd1;
      end
      default: begin
        head_next  = head_reg;
        tail_next  = tail_reg;
        count_next = count_reg;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count_reg    <= 2'd0;
      inflight_reg <= 1'b0;
      head_reg     <= '0;
      tail_reg     <= '0;
      words_reg    <= '0;
      drop_reg     <= 8'd0;
    end else begin
      count_reg    <= count_next;
      inflight_reg <= fifo_rd_en;
      head_reg     <= head_next;
      tail_reg     <= tail_next;
      if (pop) begin
        words_reg <= words_reg + 1'b1;
      end
      if (drop && (drop_reg != 8'hFF)) begin
        drop_reg <= drop_reg + 8'd1;
      end
    end
  end

endmodule
